// File: rtl/input_arbiter.sv
// Direction-event arbiter: picks one of three controller decoders (fixed or
// auto-locking), cleans contradictory directions and queues moves for game logic.
module input_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LOCK_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Choice,
    input  logic       NReadable,
    input  logic       IReadable,
    input  logic       PReadable,
    input  logic [3:0] NDir,
    input  logic [3:0] IDir,
    input  logic [3:0] PDir,
    output logic       MoveValid,
    output logic [3:0] MoveDir,
    input  logic       MoveReady,
    output logic [1:0] ActiveSrc,
    output logic       Overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_RELOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [1:0] SRC_SNES  = 2'b00;
    localparam logic [1:0] SRC_IR    = 2'b01;
    localparam logic [1:0] SRC_PS2   = 2'b10;
    localparam logic [1:0] SRC_NONE  = 2'b11;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // Opposing directions cancel each other; the other axis survives.
    function automatic logic [3:0] clean_dir(input logic [3:0] dir);
        logic [3:0] res;
        res = dir;
        if (dir[3] && dir[2]) res[3:2] = 2'b00;
        if (dir[1] && dir[0]) res[1:0] = 2'b00;
        return res;
    endfunction

    // Stage p0: strobe qualification and conflict cleanup
    logic [3:0] n_dir_p0, i_dir_p0, p_dir_p0;
    logic       n_vld_p0, i_vld_p0, p_vld_p0;

    assign n_dir_p0 = clean_dir(NDir);
    assign i_dir_p0 = clean_dir(IDir);
    assign p_dir_p0 = clean_dir(PDir);
    assign n_vld_p0 = NReadable && (n_dir_p0 != 4'b0000);
    assign i_vld_p0 = IReadable && (i_dir_p0 != 4'b0000);
    assign p_vld_p0 = PReadable && (p_dir_p0 != 4'b0000);

    // The first cycle after reset only arms the compare, so the reset value never flushes.
    logic [1:0] prev_choice;
    logic       armed;
    logic       choice_chg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev_choice <= 2'b11;
            armed       <= 1'b0;
        end else begin
            prev_choice <= Choice;
            armed       <= 1'b1;
        end
    end

    assign choice_chg = armed && (Choice != prev_choice);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [LOCK_W-1:0] lock_q, lock_d;

    logic       owner_vld;
    logic [3:0] owner_dir;

    always_comb begin
        owner_vld = 1'b0;
        owner_dir = 4'b0000;
        case (owner_q)
            SRC_SNES: begin owner_vld = n_vld_p0; owner_dir = n_dir_p0; end
            SRC_IR:   begin owner_vld = i_vld_p0; owner_dir = i_dir_p0; end
            SRC_PS2:  begin owner_vld = p_vld_p0; owner_dir = p_dir_p0; end
            default:  begin owner_vld = 1'b0;     owner_dir = 4'b0000;  end
        endcase
    end

    // Arbitration: a single accepted event per cycle, none in a change-detect cycle.
    logic       acc_vld;
    logic [1:0] acc_src;
    logic [3:0] acc_dir;

    always_comb begin
        acc_vld = 1'b0;
        acc_src = SRC_NONE;
        acc_dir = 4'b0000;
        if (!choice_chg) begin
            case (Choice)
                SRC_SNES: if (n_vld_p0) begin acc_vld = 1'b1; acc_src = SRC_SNES; acc_dir = n_dir_p0; end
                SRC_IR:   if (i_vld_p0) begin acc_vld = 1'b1; acc_src = SRC_IR;   acc_dir = i_dir_p0; end
                SRC_PS2:  if (p_vld_p0) begin acc_vld = 1'b1; acc_src = SRC_PS2;  acc_dir = p_dir_p0; end
                default: begin
                    if (state_q == S_LOCKED) begin
                        if (owner_vld) begin
                            acc_vld = 1'b1;
                            acc_src = owner_q;
                            acc_dir = owner_dir;
                        end
                    end else if (n_vld_p0) begin
                        acc_vld = 1'b1; acc_src = SRC_SNES; acc_dir = n_dir_p0;
                    end else if (i_vld_p0) begin
                        acc_vld = 1'b1; acc_src = SRC_IR;   acc_dir = i_dir_p0;
                    end else if (p_vld_p0) begin
                        acc_vld = 1'b1; acc_src = SRC_PS2;  acc_dir = p_dir_p0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            owner_q <= SRC_NONE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
        end
    end

    // Ownership only exists in auto mode; manual modes park the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        if (choice_chg || (Choice != MODE_AUTO)) begin
            state_d = S_IDLE;
            owner_d = SRC_NONE;
            lock_d  = '0;
        end else if (state_q == S_IDLE) begin
            if (acc_vld) begin
                state_d = S_LOCKED;
                owner_d = acc_src;
                lock_d  = LOCK_RELOAD;
            end
        end else begin
            if (acc_vld) begin
                lock_d = LOCK_RELOAD;
            end else if (lock_q == '0) begin
                state_d = S_IDLE;
                owner_d = SRC_NONE;
            end else begin
                lock_d = lock_q - LOCK_W'(1);
            end
        end
    end

    always_comb begin
        ActiveSrc = SRC_NONE;
        if (Reset) begin
            ActiveSrc = SRC_NONE;
        end else if (Choice != MODE_AUTO) begin
            ActiveSrc = Choice;
        end else if (state_q == S_LOCKED) begin
            ActiveSrc = owner_q;
        end
    end

    // Stage p1: move FIFO
    logic [3:0]       mem_p1 [FIFO_DEPTH];
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [CNT_W-1:0] count_p1;
    logic             ovf_p1;
    logic             empty, full, deq, enq, drop;

    assign empty = (count_p1 == '0);
    assign full  = (count_p1 == CNT_W'(FIFO_DEPTH));
    assign deq   = !empty && MoveReady;
    assign enq   = acc_vld && (!full || deq);
    assign drop  = acc_vld && full && !deq;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_p1  <= '0;
            tail_p1  <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
        end else begin
            if (choice_chg) begin
                head_p1  <= '0;
                tail_p1  <= '0;
                count_p1 <= '0;
            end else begin
                if (enq) tail_p1 <= tail_p1 + PTR_W'(1);
                if (deq) head_p1 <= head_p1 + PTR_W'(1);
                if (enq && !deq) begin
                    count_p1 <= count_p1 + CNT_W'(1);
                end else if (!enq && deq) begin
                    count_p1 <= count_p1 - CNT_W'(1);
                end
            end
            if (drop) ovf_p1 <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (enq) mem_p1[tail_p1] <= acc_dir;
    end

    assign MoveValid = !empty;
    assign MoveDir   = empty ? 4'b0000 : mem_p1[head_p1];
    assign Overflow  = ovf_p1;

endmodule

// File: tb/tb_input_arbiter.sv
// Randomized and directed bench for input_arbiter: a reference model fills an
// expected-move queue, a monitor drains it against the DUT move port.
module tb_input_arbiter;

    localparam int DEPTH = 4;
    localparam int LOCK  = 8;

    logic       Clock, Reset;
    logic [1:0] Choice;
    logic       NReadable, IReadable, PReadable;
    logic [3:0] NDir, IDir, PDir;
    logic       MoveValid, MoveReady, Overflow;
    logic [3:0] MoveDir;
    logic [1:0] ActiveSrc;

    input_arbiter #(.FIFO_DEPTH(DEPTH), .LOCK_CYCLES(LOCK)) dut (
        .Clock(Clock), .Reset(Reset), .Choice(Choice),
        .NReadable(NReadable), .IReadable(IReadable), .PReadable(PReadable),
        .NDir(NDir), .IDir(IDir), .PDir(PDir),
        .MoveValid(MoveValid), .MoveDir(MoveDir), .MoveReady(MoveReady),
        .ActiveSrc(ActiveSrc), .Overflow(Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q[$];
    bit         popped   = 0;
    int         m_owner  = -1;
    int         m_last   = -1000;
    int         cyc      = 0;
    logic [1:0] m_prev   = 2'b11;
    bit         m_armed  = 0;
    bit         m_ovf    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] tb_clean(input logic [3:0] d);
        logic [1:0] v, h;
        v = d[3:2];
        h = d[1:0];
        if (v == 2'b11) v = 2'b00;
        if (h == 2'b11) h = 2'b00;
        return {v, h};
    endfunction

    // Monitor: compares the presented move against the expected queue head.
    always @(negedge Clock) begin
        if (Reset) begin
            check("rst_valid", MoveValid, 0);
            check("rst_dir", MoveDir, 4'b0000);
        end else if (exp_q.size() > 0) begin
            check("move_valid", MoveValid, 1);
            check("move_dir", MoveDir, exp_q[0]);
            if (MoveReady) begin
                void'(exp_q.pop_front());
                popped = 1;
            end
        end else begin
            check("idle_valid", MoveValid, 0);
        end
    end

    // Reference model: decides this cycle's acceptance from the rules.
    task automatic model_step();
        logic [3:0] cd [3];
        bit         sv [3];
        bit         locked, chg;
        int         src, exp_src, pre;
        if (Reset) begin
            check("rst_src", ActiveSrc, 2'b11);
            check("rst_ovf", Overflow, 0);
            exp_q.delete();
            m_owner = -1; m_ovf = 0; m_armed = 0; m_prev = 2'b11; popped = 0;
            cyc++;
            return;
        end
        locked  = (Choice == 2'b11) && (m_owner >= 0) && (cyc - m_last <= LOCK);
        exp_src = (Choice != 2'b11) ? int'(Choice) : (locked ? m_owner : 3);
        check("active_src", ActiveSrc, exp_src);
        check("overflow", Overflow, m_ovf);
        chg     = m_armed && (Choice != m_prev);
        m_armed = 1;
        m_prev  = Choice;
        cd[0] = tb_clean(NDir); cd[1] = tb_clean(IDir); cd[2] = tb_clean(PDir);
        sv[0] = NReadable && (cd[0] != 0);
        sv[1] = IReadable && (cd[1] != 0);
        sv[2] = PReadable && (cd[2] != 0);
        src = -1;
        if (chg) begin
            exp_q.delete();
            m_owner = -1;
        end else if (Choice != 2'b11) begin
            if (sv[Choice]) src = Choice;
        end else if (locked) begin
            if (sv[m_owner]) begin src = m_owner; m_last = cyc; end
        end else begin
            for (int s = 0; s < 3; s++) if (src < 0 && sv[s]) src = s;
            if (src >= 0) begin m_owner = src; m_last = cyc; end
        end
        if (src >= 0) begin
            pre = exp_q.size() + int'(popped);
            if (pre < DEPTH || popped) exp_q.push_back(cd[src]);
            else m_ovf = 1;
        end
        popped = 0;
        cyc++;
    endtask

    always @(negedge Clock) begin
        #1;
        model_step();
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        NReadable = 0; IReadable = 0; PReadable = 0;
    endtask

    initial begin
        Reset = 1; Choice = 2'b00; MoveReady = 0;
        NReadable = 0; IReadable = 0; PReadable = 0;
        NDir = 0; IDir = 0; PDir = 0;
        repeat (2) tick();
        Reset = 0;

        // Single SNES move held until accepted
        NDir = 4'b1000; NReadable = 1; tick();
        check("req34_valid", MoveValid, 1);
        check("req34_dir", MoveDir, 4'b1000);
        tick(); tick();
        check("req34_hold", MoveDir, 4'b1000);
        MoveReady = 1; tick(); MoveReady = 0;
        check("req34_done", MoveValid, 0);

        // IR only: Up+Down cancels, other sources ignored
        Choice = 2'b01; tick(); tick();
        IDir = 4'b1100; IReadable = 1; tick();
        IDir = 4'b1110; IReadable = 1; NDir = 4'b1000; NReadable = 1; PDir = 4'b0100; PReadable = 1;
        tick();
        check("req35_dir", MoveDir, 4'b0010);
        tick();
        MoveReady = 1; tick(); MoveReady = 0;
        check("req35_single", MoveValid, 0);

        // Auto mode: priority, lock, expiry
        Choice = 2'b11; tick(); tick();
        NDir = 4'b0001; PDir = 4'b0100; NReadable = 1; PReadable = 1; tick();
        check("req36_owner", ActiveSrc, 2'b00);
        tick(); tick();
        PDir = 4'b0010; PReadable = 1; tick();
        repeat (5) tick();
        PDir = 4'b1000; PReadable = 1; tick();
        check("req36_newowner", ActiveSrc, 2'b10);
        MoveReady = 1; repeat (3) tick(); MoveReady = 0;

        // Overflow on five events into a depth-4 FIFO
        Choice = 2'b00; tick(); tick();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: NDir = 4'b1000;
                1: NDir = 4'b0100;
                2: NDir = 4'b0010;
                3: NDir = 4'b0001;
                default: NDir = 4'b1001;
            endcase
            NReadable = 1; tick();
        end
        check("req37_ovf", Overflow, 1);
        MoveReady = 1; repeat (5) tick(); MoveReady = 0;
        check("req37_ovf_sticky", Overflow, 1);

        // Full FIFO with simultaneous enqueue and dequeue
        Reset = 1; tick(); Reset = 0;
        for (int k = 0; k < 4; k++) begin
            NDir = 4'(k + 4); NReadable = 1; tick();
        end
        NDir = 4'b0110; NReadable = 1; MoveReady = 1; tick(); MoveReady = 0;
        check("req38_no_ovf", Overflow, 0);
        MoveReady = 1; repeat (5) tick(); MoveReady = 0;

        // Flush on Choice change, then asynchronous reset mid-queue
        for (int k = 0; k < 3; k++) begin
            NDir = 4'b1001; NReadable = 1; tick();
        end
        Choice = 2'b10; tick();
        check("req39_flush", MoveValid, 0);
        check("req39_src", ActiveSrc, 2'b10);
        for (int k = 0; k < 3; k++) begin
            PDir = 4'b0101; PReadable = 1; tick();
        end
        Reset = 1; #1;
        check("req39_rst_valid", MoveValid, 0);
        check("req39_rst_dir", MoveDir, 4'b0000);
        check("req39_rst_src", ActiveSrc, 2'b11);
        tick(); Reset = 0;

        // Randomized traffic across densities, modes and consumer rates
        for (int i = 0; i < 3000; i++) begin
            int dmax;
            dmax = ((i / 500) % 3 == 0) ? 1 : (((i / 500) % 3 == 1) ? 7 : 29);
            if ($urandom_range(0, 199) == 0)
                Choice = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            NDir = 4'($urandom_range(0, 15));
            IDir = 4'($urandom_range(0, 15));
            PDir = 4'($urandom_range(0, 15));
            NReadable = ($urandom_range(0, dmax) == 0);
            IReadable = ($urandom_range(0, dmax) == 0);
            PReadable = ($urandom_range(0, dmax) == 0);
            MoveReady = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            Reset = ($urandom_range(0, 999) == 0);
            tick();
        end

        Reset = 0; MoveReady = 1;
        repeat (10) tick();
        check("final_empty", exp_q.size(), 0);
        check("final_valid", MoveValid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
